// File: rtl/intra_mb_scheduler_if.sv
// Job handshake and coordinate bus between the intra MB scheduler and the encoder_intra datapath.
// The master side is the scheduler; the slave side is the datapath plus the top-level enable source.
interface intra_mb_scheduler_if #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 32
);
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(LENGTH);
    localparam int MXW = (WIDTH / 16 > 1) ? $clog2(WIDTH / 16) : 1;
    localparam int MYW = (LENGTH / 16 > 1) ? $clog2(LENGTH / 16) : 1;

    logic           enable;
    logic           done_luma4x4;
    logic           done_chromab8x8;
    logic           done_chromar8x8;
    logic           start_luma4x4;
    logic           start_chromab8x8;
    logic           start_chromar8x8;
    logic [XW-1:0]  blk_x;
    logic [YW-1:0]  blk_y;
    logic [3:0]     blk_idx;
    logic [MXW-1:0] mb_x;
    logic [MYW-1:0] mb_y;
    logic           busy;
    logic           frame_done;
    logic           err_spurious;

    modport master (
        input  enable, done_luma4x4, done_chromab8x8, done_chromar8x8,
        output start_luma4x4, start_chromab8x8, start_chromar8x8,
        output blk_x, blk_y, blk_idx, mb_x, mb_y, busy, frame_done, err_spurious
    );

    modport slave (
        output enable, done_luma4x4, done_chromab8x8, done_chromar8x8,
        input  start_luma4x4, start_chromab8x8, start_chromar8x8,
        input  blk_x, blk_y, blk_idx, mb_x, mb_y, busy, frame_done, err_spurious
    );
endinterface

// File: rtl/intra_mb_scheduler.sv
// Frame sequencer: raster macroblocks, 16 luma 4x4 jobs in z-order, then Cb and Cr 8x8 jobs.
// Every job is a one-cycle start pulse followed by a wait for the matching done pulse.
module intra_mb_scheduler #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    intra_mb_scheduler_if.master  bus
);
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(LENGTH);
    localparam int MXW = (WIDTH / 16 > 1) ? $clog2(WIDTH / 16) : 1;
    localparam int MYW = (LENGTH / 16 > 1) ? $clog2(LENGTH / 16) : 1;
    localparam logic [MXW-1:0] MB_COLS_M1 = MXW'(WIDTH / 16 - 1);
    localparam logic [MYW-1:0] MB_ROWS_M1 = MYW'(LENGTH / 16 - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        L_START  = 4'd1,
        L_WAIT   = 4'd2,
        CB_START = 4'd3,
        CB_WAIT  = 4'd4,
        CR_START = 4'd5,
        CR_WAIT  = 4'd6,
        MB_NEXT  = 4'd7,
        F_DONE   = 4'd8
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     blk_idx_q, blk_idx_d;
    logic [MXW-1:0] mb_x_q, mb_x_d;
    logic [MYW-1:0] mb_y_q, mb_y_d;
    logic [XW-1:0]  blk_x_q, blk_x_d;
    logic [YW-1:0]  blk_y_q, blk_y_d;
    logic           start_l_q, start_l_d;
    logic           start_cb_q, start_cb_d;
    logic           start_cr_q, start_cr_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           err_q, err_d;

    // Next-state and job/macroblock counter logic.
    always_comb begin
        state_d   = state_q;
        blk_idx_d = blk_idx_q;
        mb_x_d    = mb_x_q;
        mb_y_d    = mb_y_q;
        case (state_q)
            IDLE:     if (bus.enable) state_d = L_START; else state_d = IDLE;
            // A START state leaves once its registered pulse has actually been driven.
            L_START:  if (start_l_q) state_d = L_WAIT; else state_d = L_START;
            L_WAIT: begin
                if (bus.done_luma4x4) begin
                    if (blk_idx_q == 4'd15) begin
                        blk_idx_d = 4'd0;
                        state_d   = CB_START;
                    end else begin
                        blk_idx_d = blk_idx_q + 4'd1;
                        state_d   = L_START;
                    end
                end else begin
                    state_d = L_WAIT;
                end
            end
            CB_START: if (start_cb_q) state_d = CB_WAIT; else state_d = CB_START;
            CB_WAIT:  if (bus.done_chromab8x8) state_d = CR_START; else state_d = CB_WAIT;
            CR_START: if (start_cr_q) state_d = CR_WAIT; else state_d = CR_START;
            CR_WAIT:  if (bus.done_chromar8x8) state_d = MB_NEXT; else state_d = CR_WAIT;
            MB_NEXT: begin
                if (mb_x_q == MB_COLS_M1) begin
                    mb_x_d = '0;
                    if (mb_y_q == MB_ROWS_M1) begin
                        mb_y_d  = '0;
                        state_d = F_DONE;
                    end else begin
                        mb_y_d  = mb_y_q + MYW'(1);
                        state_d = L_START;
                    end
                end else begin
                    mb_x_d  = mb_x_q + MXW'(1);
                    state_d = L_START;
                end
            end
            F_DONE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Registered-output values derived from the upcoming state.
    always_comb begin
        // Enable is sampled one cycle ahead so the start pulse can come straight from a flop.
        start_l_d    = bus.enable && (state_d == L_START);
        start_cb_d   = bus.enable && (state_d == CB_START);
        start_cr_d   = bus.enable && (state_d == CR_START);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == F_DONE);
        err_d        = err_q
                     | (bus.done_luma4x4    & (state_q != L_WAIT))
                     | (bus.done_chromab8x8 & (state_q != CB_WAIT))
                     | (bus.done_chromar8x8 & (state_q != CR_WAIT));
        if (state_d == L_START) begin
            blk_x_d = XW'({mb_x_d, 4'b0000}) + XW'({blk_idx_d[2], blk_idx_d[0], 2'b00});
            blk_y_d = YW'({mb_y_d, 4'b0000}) + YW'({blk_idx_d[3], blk_idx_d[1], 2'b00});
        end else if ((state_d == CB_START) || (state_d == CR_START)) begin
            blk_x_d = XW'({mb_x_d, 3'b000});
            blk_y_d = YW'({mb_y_d, 3'b000});
        end else begin
            blk_x_d = blk_x_q;
            blk_y_d = blk_y_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            blk_idx_q    <= 4'd0;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            start_l_q    <= 1'b0;
            start_cb_q   <= 1'b0;
            start_cr_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_idx_q    <= blk_idx_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            start_l_q    <= start_l_d;
            start_cb_q   <= start_cb_d;
            start_cr_q   <= start_cr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.start_luma4x4    = start_l_q;
    assign bus.start_chromab8x8 = start_cb_q;
    assign bus.start_chromar8x8 = start_cr_q;
    assign bus.blk_x            = blk_x_q;
    assign bus.blk_y            = blk_y_q;
    assign bus.blk_idx          = blk_idx_q;
    assign bus.mb_x             = mb_x_q;
    assign bus.mb_y             = mb_y_q;
    assign bus.busy             = busy_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.err_spurious     = err_q;
endmodule

// File: doc/intra_mb_scheduler.md
Name: intra_mb_scheduler

Overview:
Frame-level sequencer for encoder_intra. It walks the frame macroblock by macroblock in raster order. For each 16x16 macroblock it issues 16 luma 4x4 jobs in H.264 z-order, then one Cb 8x8 job, then one Cr 8x8 job. Each job is a one-cycle start pulse with block coordinates, and the scheduler waits for the matching done_* pulse before issuing the next job. It sits between the top-level enable and the encoder_intra datapath.

Parameters:
WIDTH, 32, frame width in luma pixels; multiple of 16
LENGTH, 32, frame height in luma pixels; multiple of 16

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  level; permits frame start and job issue
done_luma4x4  in  1  one-cycle pulse: current luma 4x4 job complete
done_chromab8x8  in  1  one-cycle pulse: current Cb 8x8 job complete
done_chromar8x8  in  1  one-cycle pulse: current Cr 8x8 job complete
start_luma4x4  out  1  one-cycle job-start pulse
start_chromab8x8  out  1  one-cycle job-start pulse
start_chromar8x8  out  1  one-cycle job-start pulse
blk_x  out  clog2(WIDTH)  job x origin: luma pixels for luma jobs, chroma pixels for chroma jobs
blk_y  out  clog2(LENGTH)  job y origin, same units as blk_x
blk_idx  out  4  luma z-order index 0..15; 0 during chroma jobs
mb_x  out  max(1,clog2(WIDTH/16))  current macroblock column
mb_y  out  max(1,clog2(LENGTH/16))  current macroblock row
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last Cr job of the frame
err_spurious  out  1  sticky flag: done pulse outside the matching WAIT state

Behaviour:
- Reset is asynchronous and active-high. It applies at any time, including mid-frame.
  - All outputs go to 0, FSM goes to IDLE, counters clear.
  - Any job in flight is abandoned; a later done pulse for it sets err_spurious.
- All outputs are registered.
- FSM states: IDLE, L_START, L_WAIT, CB_START, CB_WAIT, CR_START, CR_WAIT, MB_NEXT, F_DONE.
- IDLE:
  - enable=1 → L_START; mb_x, mb_y and blk_idx are 0.
  - enable=0 → stay in IDLE.
- *_START states:
  - enable=1: the matching start_* pulse is high for exactly this cycle, blk_x/blk_y/blk_idx are valid, next state is the matching *_WAIT.
  - enable=0: hold the state with no pulse; coordinates stay stable.
- Luma coordinates:
  - blk_x = mb_x*16 + 4*{blk_idx[2],blk_idx[0]}
  - blk_y = mb_y*16 + 4*{blk_idx[3],blk_idx[1]}
- Chroma coordinates: blk_x = mb_x*8, blk_y = mb_y*8.
- Coordinates hold through the WAIT state and change only on entry to the next START state.
- L_WAIT on done_luma4x4:
  - blk_idx<15 → blk_idx+1, go to L_START.
  - blk_idx=15 → blk_idx=0, go to CB_START.
- CB_WAIT on done_chromab8x8 → CR_START.
- CR_WAIT on done_chromar8x8 → MB_NEXT.
- MB_NEXT (one cycle): advance the macroblock position.
  - mb_x<WIDTH/16-1 → mb_x+1.
  - Otherwise mb_x=0 and mb_y+1.
  - If that was the last macroblock (wrap of both mb_x and mb_y) → F_DONE with mb_x=mb_y=0; otherwise → L_START.
- F_DONE: frame_done=1 for this cycle only, then IDLE. enable still high in IDLE starts the next frame, so continuous mode has a minimum 2-cycle gap (F_DONE, IDLE) before the next L_START.
- A done pulse takes effect only in the matching WAIT state. It is ignored in every other state and sets err_spurious; this includes a done in the same cycle as the START pulse and a done from the wrong component. err_spurious clears only on reset.
- Done pulses simultaneous with a state transition follow the rule above, judged by the current (pre-edge) state.
- Throughput: minimum 2 cycles per job. One macroblock takes 18 jobs + MB_NEXT = 37 cycles minimum.

Test Plan:
1. Reset 3 cycles then release; enable=1; a responder returns done one cycle after each start (i.e. in the WAIT cycle) → 72 start pulses total (64 luma, 4 Cb, 4 Cr). frame_done rises exactly once, 4*37=148 cycles after the first L_START, and busy is high throughout.
2. MB (1,0), luma blk_idx sequence 0..15 → (blk_x,blk_y) = (16,0),(20,0),(16,4),(20,4),(24,0),(28,0),(24,4),(28,4),(16,8),(20,8),(16,12),(20,12),(24,8),(28,8),(24,12),(28,12). Then Cb and Cr both at (8,0).
3. Responder delays done 10 cycles; drop enable for 5 cycles while in CB_START → no start pulse while enable=0. start_chromab8x8 fires one cycle after enable returns, coordinates stay stable throughout, and frame completes normally.
4. Inject done_chromar8x8 during L_WAIT and done_luma4x4 in IDLE → FSM state unchanged, err_spurious=1 and stays high until reset.
5. Assert reset during MB 2, luma blk_idx 7 → outputs 0 and busy=0 immediately (asynchronous). After release with enable=1, the restart begins at mb (0,0), blk_idx 0.
6. enable held high across two frames → second frame's first start_luma4x4 occurs 2 cycles after the frame_done pulse, at (0,0).
